pipe_skid_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 13 +
 rtl/flopenr.sv | 20 ++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffered pipeline register.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a 2-entry skid buffer and a registered in_ready,
// so no ready path runs combinationally back through the stage.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int N = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Handshake: a transfer fires on a rising edge where valid & ready are
    // both high. Valid never depends on ready on either side, and the head
    // entry stays stable while out_valid is high and out_ready is low.

    skid_state_t state;
    skid_state_t next_state;

    logic         write_fire;
    logic         read_fire;
    logic         main_en;
    logic         skid_en;
    logic [N-1:0] main_d;
    logic [N-1:0] main_q;
    logic [N-1:0] skid_q;

    assign write_fire = in_valid & in_ready;
    assign read_fire  = out_valid & out_ready;

    always_comb begin
        next_state = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = in_data;
        // Flush only moves the state; data registers keep their contents.
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (write_fire) begin
                        next_state = ONE;
                        main_en    = 1'b1;
                    end
                end
                ONE: begin
                    if (write_fire && read_fire) begin
                        main_en = 1'b1;
                    end else if (write_fire) begin
                        next_state = FULL;
                        skid_en    = 1'b1;
                    end else if (read_fire) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (read_fire) begin
                        next_state = ONE;
                        main_en    = 1'b1;
                        main_d     = skid_q;
                    end
                end
                default: begin
                    next_state = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    flopenr #(.N(N)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    flopenr #(.N(N)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    // The state encoding is the entry count, which also exposes the FSM.
    assign occupancy = OCC_W'(state);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench: the model is a FIFO of capacity 2 held as a queue;
// drivers push accepted writes, monitors pop and compare on each read.
module tb_pipe_skid_reg;

    localparam int N = 64;
    localparam int M = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   occupancy;

    logic         in_valid32;
    logic         in_ready32;
    logic [M-1:0] in_data32;
    logic         out_valid32;
    logic         out_ready32;
    logic [M-1:0] out_data32;
    logic [1:0]   occupancy32;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] exp_q[$];
    logic [M-1:0] exp32_q[$];
    logic         prev_reset = 1'b1;
    logic         exp_ready  = 1'b0;
    logic         exp32_ready = 1'b0;
    int           sz;
    int           sz32;
    logic [N-1:0] head;
    logic [M-1:0] head32;

    always #5 clk = ~clk;

    pipe_skid_reg #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(.N(M)) dut32 (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_data   (in_data32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_data  (out_data32),
        .occupancy (occupancy32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are compared against the model before any update.
    always @(negedge clk) begin
        sz        = exp_q.size();
        exp_ready = !prev_reset && (sz < 2);
        check("occupancy", 64'(occupancy), 64'(sz));
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        if (prev_reset) check("reset_data", out_data, 64'd0);
        if (!reset && out_ready && sz > 0) begin
            head = exp_q.pop_front();
            check("out_data", out_data, head);
        end
        prev_reset = reset;

        sz32        = exp32_q.size();
        exp32_ready = !reset && (sz32 < 2);
        check("occupancy32", 64'(occupancy32), 64'(sz32));
        check("out_valid32", 64'(out_valid32), 64'(sz32 != 0));
        if (out_ready32 && sz32 > 0) begin
            head32 = exp32_q.pop_front();
            check("out_data32", 64'(out_data32), 64'(head32));
        end
    end

    task automatic drive(input logic iv, input logic [N-1:0] d, input logic ordy,
                         input logic fl, input logic rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(negedge clk);
        #1;
        if (rs || fl) begin
            exp_q.delete();
        end else if (iv && exp_ready) begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic iv, input logic [M-1:0] d, input logic ordy);
        in_valid32  = iv;
        in_data32   = d;
        out_ready32 = ordy;
        @(negedge clk);
        #1;
        if (iv && exp32_ready) exp32_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid32  = 1'b0;
        in_data32   = '0;
        out_ready32 = 1'b0;

        // Reset held two cycles while upstream offers data.
        drive(1'b1, 64'hAA, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 64'hAA, 1'b0, 1'b0, 1'b1);

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure fills the skid entry, then drains.
        drive(1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd6, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Simultaneous read and write while holding one entry.
        drive(1'b1, 64'd7, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd8, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Flush from FULL discards the concurrent write of 11.
        drive(1'b1, 64'd9, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd10, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd11, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Flush coinciding with a read still delivers the head.
        drive(1'b1, 64'd12, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd13, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Reset mid-transfer drops everything.
        drive(1'b1, 64'd14, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd15, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'd16, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom},
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0), 1'b0);
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // 32-bit instance: extreme values pass through unchanged.
        drive32(1'b1, 32'hFFFF_FFFF, 1'b1);
        drive32(1'b1, 32'h0000_0000, 1'b1);
        drive32(1'b1, 32'hFFFF_FFFF, 1'b1);
        drive32(1'b1, 32'h8000_0001, 1'b1);
        drive32(1'b0, 32'h0, 1'b1);
        drive32(1'b0, 32'h0, 1'b1);
        check("in_ready32", 64'(in_ready32), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
